// File: rtl/coolgirl_scanline_irq_if.sv
// CPU/PPU snoop bus and IRQ outputs of the MMC3-style scanline IRQ block.
// master = cartridge/bus side, slave = the IRQ generator.
interface coolgirl_scanline_irq_if;
    logic        mapper_sel;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        ppu_a12;
    logic        irq_pending;
    logic [7:0]  irq_counter;

    modport master (
        output mapper_sel, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
        input  irq_pending, irq_counter
    );

    modport slave (
        input  mapper_sel, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
        output irq_pending, irq_counter
    );
endinterface

// File: rtl/coolgirl_scanline_irq.sv
// MMC3-style scanline IRQ: filters PPU A12 rises into a scanline clock and counts down.
// Define MMC3_IRQ_REV_A_EN for rev A behaviour (IRQ only on decrement to zero).
module coolgirl_scanline_irq #(
    parameter int         A12_LOW_MIN = 3,
    parameter logic [7:0] LATCH_INIT  = 8'h00
) (
    input  logic                   m2,
    input  logic                   reset_n,
    coolgirl_scanline_irq_if.slave bus
);

    localparam logic [2:0] LOW_MAX = 3'(A12_LOW_MIN);

    logic       a12_s1, a12_s2, a12_prev;
    logic [2:0] low_cnt;
    logic [7:0] counter;
    logic [7:0] latch;
    logic       reload_flag;
    logic       irq_en;
    logic       irq_pending;

    logic       wr;
    logic       wr_c000, wr_c001, wr_e000, wr_e001;
    logic       a12_edge;
    logic       reload;
    logic [7:0] edge_cnt;
    logic       irq_set;
    logic       unused_addr;

    // Only A14, A13 and A0 take part in the register decode.
    assign unused_addr = ^bus.cpu_addr_in[12:1];

    assign wr      = ~bus.romsel & ~bus.cpu_rw_in;
    assign wr_c000 = wr &  bus.cpu_addr_in[14] & ~bus.cpu_addr_in[13] & ~bus.cpu_addr_in[0];
    assign wr_c001 = wr &  bus.cpu_addr_in[14] & ~bus.cpu_addr_in[13] &  bus.cpu_addr_in[0];
    assign wr_e000 = wr &  bus.cpu_addr_in[14] &  bus.cpu_addr_in[13] & ~bus.cpu_addr_in[0];
    assign wr_e001 = wr &  bus.cpu_addr_in[14] &  bus.cpu_addr_in[13] &  bus.cpu_addr_in[0];

    // A rise only counts after a full low window, which rejects short A12 glitches.
    assign a12_edge = a12_s2 & ~a12_prev & (low_cnt == LOW_MAX);

    always_comb begin
        reload   = (counter == 8'd0) | reload_flag;
        edge_cnt = reload ? latch : counter - 8'd1;
`ifdef MMC3_IRQ_REV_A_EN
        irq_set  = a12_edge & irq_en & ~reload & (edge_cnt == 8'd0);
`else
        irq_set  = a12_edge & irq_en & (edge_cnt == 8'd0);
`endif
    end

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            a12_s1      <= 1'b0;
            a12_s2      <= 1'b0;
            a12_prev    <= 1'b0;
            low_cnt     <= 3'd0;
            counter     <= 8'd0;
            latch       <= LATCH_INIT;
            reload_flag <= 1'b0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
        end else if (!bus.mapper_sel) begin
            a12_s1      <= 1'b0;
            a12_s2      <= 1'b0;
            a12_prev    <= 1'b0;
            low_cnt     <= 3'd0;
            counter     <= 8'd0;
            latch       <= LATCH_INIT;
            reload_flag <= 1'b0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            a12_s1   <= bus.ppu_a12;
            a12_s2   <= a12_s1;
            a12_prev <= a12_s2;

            if (a12_s2)
                low_cnt <= 3'd0;
            else if (low_cnt != LOW_MAX)
                low_cnt <= low_cnt + 3'd1;

            if (wr_c000)
                latch <= bus.cpu_data_in;

            // A $C001 write overrides a coincident scanline edge.
            if (wr_c001) begin
                counter     <= 8'd0;
                reload_flag <= 1'b1;
            end else if (a12_edge) begin
                counter     <= edge_cnt;
                reload_flag <= 1'b0;
            end

            if (wr_e000)
                irq_en <= 1'b0;
            else if (wr_e001)
                irq_en <= 1'b1;

            // Acknowledge beats a coincident IRQ set.
            if (wr_e000)
                irq_pending <= 1'b0;
            else if (irq_set)
                irq_pending <= 1'b1;
        end
    end

    assign bus.irq_pending = irq_pending;
    assign bus.irq_counter = counter;

endmodule

// File: tb/tb_coolgirl_scanline_irq.sv
// Randomised + directed check of coolgirl_scanline_irq against a behavioural model.
module tb_coolgirl_scanline_irq;

    localparam logic [7:0] LATCH_INIT = 8'h00;
    localparam logic [14:0] A_C000 = 15'h4000;
    localparam logic [14:0] A_C001 = 15'h4001;
    localparam logic [14:0] A_E000 = 15'h6000;
    localparam logic [14:0] A_E001 = 15'h6001;
`ifdef MMC3_IRQ_REV_A_EN
    localparam int ZERO_LATCH_IRQ = 0;
`else
    localparam int ZERO_LATCH_IRQ = 1;
`endif

    logic m2;
    logic reset_n;
    coolgirl_scanline_irq_if bus();

    coolgirl_scanline_irq #(.A12_LOW_MIN(3), .LATCH_INIT(LATCH_INIT)) dut (
        .m2     (m2),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_cnt, m_latch, m_flag, m_en, m_pend;
    bit a12_hist[$];   // A12 samples since last clear, two sync-stage zeros prefilled
    bit a12_lvl;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_cnt = 0; m_latch = int'(LATCH_INIT); m_flag = 0; m_en = 0; m_pend = 0;
        a12_hist = {};
        a12_hist.push_back(1'b0);
        a12_hist.push_back(1'b0);
    endtask

    // One m2 fall: a scanline edge is an A12 high seen two falls late, preceded by 3 lows.
    task automatic m_fall();
        bit w, edge_seen, set, rld;
        int nc;
        if (!reset_n || !bus.mapper_sel) begin
            m_clear();
            return;
        end
        w = !bus.romsel && !bus.cpu_rw_in && bus.cpu_addr_in[14];
        a12_hist.push_back(bus.ppu_a12);
        if (a12_hist.size() > 6) void'(a12_hist.pop_front());
        edge_seen = (a12_hist.size() == 6) && a12_hist[3] && !a12_hist[2]
                    && !a12_hist[1] && !a12_hist[0];
        set = 1'b0;
        if (edge_seen) begin
            rld = (m_cnt == 0) || (m_flag != 0);
            nc  = rld ? m_latch : m_cnt - 1;
`ifdef MMC3_IRQ_REV_A_EN
            set = (m_en != 0) && !rld && (nc == 0);
`else
            set = (m_en != 0) && (nc == 0);
`endif
            m_cnt  = nc;
            m_flag = 0;
        end
        if (w) begin
            case ({bus.cpu_addr_in[13], bus.cpu_addr_in[0]})
                2'b00: m_latch = int'(bus.cpu_data_in);
                2'b01: begin m_cnt = 0; m_flag = 1; end
                2'b10: m_en = 0;
                default: m_en = 1;
            endcase
        end
        if (w && bus.cpu_addr_in[13] && !bus.cpu_addr_in[0]) m_pend = 0;
        else if (set) m_pend = 1;
    endtask

    task automatic step(input bit ms, input bit rs, input bit rw, input logic [14:0] a,
                        input logic [7:0] d, input bit a12, input bit rst_mid);
        @(posedge m2);
        reset_n = 1'b1;
        bus.mapper_sel  = ms;
        bus.romsel      = rs;
        bus.cpu_rw_in   = rw;
        bus.cpu_addr_in = a;
        bus.cpu_data_in = d;
        bus.ppu_a12     = a12;
        if (rst_mid) begin
            #2 reset_n = 1'b0;
            #1;
            chk("async_rst_pend", int'(bus.irq_pending), 0);
            chk("async_rst_cnt", int'(bus.irq_counter), 0);
        end
        @(negedge m2);
        m_fall();
        #1;
        chk("model_pend", int'(bus.irq_pending), m_pend);
        chk("model_cnt", int'(bus.irq_counter), m_cnt);
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b0, a, d, a12_lvl, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 15'h0, 8'h0, a12_lvl, 1'b0);
    endtask

    // Low then high A12 phase; optional $E000 write on the fall where the edge lands.
    task automatic pulse(input int lo, input int hi, input int ack_at);
        a12_lvl = 1'b0;
        idle(lo);
        a12_lvl = 1'b1;
        for (int i = 0; i < hi; i++) begin
            if (i == ack_at) wr(A_E000, 8'h00);
            else idle(1);
        end
    endtask

    initial begin
        bit ms, rs, rw, rst;
        logic [14:0] a;
        logic [7:0]  d;
        int run;

        reset_n = 1'b1;
        bus.mapper_sel = 1'b1; bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
        bus.cpu_addr_in = '0; bus.cpu_data_in = '0; bus.ppu_a12 = 1'b0;
        a12_lvl = 1'b0;
        m_clear();
        #1 reset_n = 1'b0;
        #2;
        chk("reset_pend", int'(bus.irq_pending), 0);
        chk("reset_cnt", int'(bus.irq_counter), 0);

        // Basic countdown 3,2,1,0 then reload
        wr(A_C000, 8'd3); wr(A_C001, 8'd0); wr(A_E001, 8'd0);
        pulse(4, 4, -1); chk("t1_rise1_cnt", int'(bus.irq_counter), 3);
        pulse(4, 4, -1); chk("t1_rise2_cnt", int'(bus.irq_counter), 2);
        pulse(4, 4, -1); chk("t1_rise3_cnt", int'(bus.irq_counter), 1);
        chk("t1_rise3_pend", int'(bus.irq_pending), 0);
        pulse(4, 4, -1); chk("t1_rise4_cnt", int'(bus.irq_counter), 0);
        chk("t1_rise4_pend", int'(bus.irq_pending), 1);
        pulse(4, 4, -1); chk("t1_rise5_cnt", int'(bus.irq_counter), 3);
        chk("t1_rise5_pend", int'(bus.irq_pending), 1);

        // Short low window swallowed
        pulse(2, 4, -1); chk("t2_short_cnt", int'(bus.irq_counter), 3);

        // Ack and re-enable
        wr(A_E000, 8'd0); chk("t3_ack_pend", int'(bus.irq_pending), 0);
        wr(A_E001, 8'd0); chk("t3_en_pend", int'(bus.irq_pending), 0);
        pulse(4, 4, -1); pulse(4, 4, -1);
        chk("t3_cnt1_pend", int'(bus.irq_pending), 0);
        pulse(4, 4, -1); chk("t3_zero_pend", int'(bus.irq_pending), 1);

        // Latch = 0
        wr(A_E000, 8'd0); wr(A_C000, 8'd0); wr(A_C001, 8'd0); wr(A_E001, 8'd0);
        for (int k = 0; k < 3; k++) begin
            pulse(4, 4, -1);
            chk("t4_cnt", int'(bus.irq_counter), 0);
            chk("t4_pend", int'(bus.irq_pending), ZERO_LATCH_IRQ);
            wr(A_E000, 8'd0); wr(A_E001, 8'd0);
        end

        // Ack on the same fall as a zero-producing edge
        wr(A_C000, 8'd1); wr(A_C001, 8'd0);
        pulse(4, 4, -1); chk("t5_reload_cnt", int'(bus.irq_counter), 1);
        pulse(4, 4, 2);
        chk("t5_pend", int'(bus.irq_pending), 0);
        chk("t5_cnt", int'(bus.irq_counter), 0);

        // Reset mid-count, then deselected write ignored
        wr(A_C000, 8'd5); wr(A_C001, 8'd0); wr(A_E001, 8'd0);
        pulse(4, 4, -1); chk("t6_cnt5", int'(bus.irq_counter), 5);
        step(1'b1, 1'b1, 1'b1, 15'h0, 8'h0, a12_lvl, 1'b1);
        step(1'b0, 1'b0, 1'b0, A_C000, 8'h77, a12_lvl, 1'b0);
        wr(A_C001, 8'd0);
        pulse(4, 4, -1); chk("t6_latch_kept", int'(bus.irq_counter), int'(LATCH_INIT));

        // Random traffic
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                a12_lvl = ~a12_lvl;
                run = $urandom_range(1, 6);
            end
            run--;
            ms  = ($urandom_range(0, 149) != 0);
            rst = ($urandom_range(0, 499) == 0);
            a   = 15'($urandom);
            d   = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) begin
                rs = 1'b0; rw = 1'b0;
            end else begin
                rs = 1'($urandom);
                rw = rs ? 1'($urandom) : 1'b1;
            end
            step(ms, rs, rw, a, d, a12_lvl, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
